// File: rtl/isa_pkg.sv
// Shared ISA definitions: field positions, opcodes, ALU encodings and ID/EX payload.
// The EX stage imports the same package so both sides agree on these encodings.
package isa_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned PC_W     = 10;
    localparam int unsigned ALU_OP_W = 4;

    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned OPC_W     = 6;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned IMM_W     = 16;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_XOR = 4'd3,
        ALU_SLL = 4'd4,
        ALU_SRL = 4'd5,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SRA = 4'd8,
        ALU_NOR = 4'd12
    } alu_op_e;

    typedef struct packed {
        logic    alu_src;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   npc;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] shamt;
        ctrl_t             ctrl;
    } id_ex_t;

    // Unrecognised funct codes fall back to ADD.
    function automatic alu_op_e funct_to_alu(input logic [FUNCT_W-1:0] funct);
        case (funct)
            FN_SLL:          return ALU_SLL;
            FN_SRL:          return ALU_SRL;
            FN_SRA:          return ALU_SRA;
            FN_SUB, FN_SUBU: return ALU_SUB;
            FN_AND:          return ALU_AND;
            FN_OR:           return ALU_OR;
            FN_XOR:          return ALU_XOR;
            FN_NOR:          return ALU_NOR;
            FN_SLT:          return ALU_SLT;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two async read ports, one sync write port, write-through bypass.
// Register 0 is hardwired to zero.
module reg_file
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    input  logic [REG_AW-1:0] ra0,
    input  logic [REG_AW-1:0] ra1,
    output logic [XLEN-1:0]   rd0_c,
    output logic [XLEN-1:0]   rd1_c
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wa] = wd;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A read of the register being written this cycle sees the new value.
    assign rd0_c = (wr_en && (wa == ra0)) ? wd : regs_q[ra0];
    assign rd1_c = (wr_en && (wa == ra1)) ? wd : regs_q[ra1];

endmodule

// File: rtl/inst_decode.sv
// ID stage: field split, control decode, operand read, load-use hazard detection
// and the ID/EX pipeline register.
module inst_decode
    import isa_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     if_id_instr,
    input  logic [PC_W-1:0]     if_id_NPC,
    input  logic                flush,
    input  logic                wb_we,
    input  logic [REG_AW-1:0]   wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic                id_stall,
    output logic                id_ex_valid,
    output logic [PC_W-1:0]     id_ex_NPC,
    output logic [XLEN-1:0]     id_ex_rs_data,
    output logic [XLEN-1:0]     id_ex_rt_data,
    output logic [XLEN-1:0]     id_ex_imm,
    output logic [REG_AW-1:0]   id_ex_rs_addr,
    output logic [REG_AW-1:0]   id_ex_rt_addr,
    output logic [REG_AW-1:0]   id_ex_shamt,
    output logic [ALU_OP_W-1:0] id_ex_alu_op,
    output logic                id_ex_alu_src,
    output logic                id_ex_reg_write,
    output logic                id_ex_mem_read,
    output logic                id_ex_mem_write,
    output logic                id_ex_mem_to_reg,
    output logic                id_ex_branch
);

    logic [OPC_W-1:0]   opcode;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm16;
    logic [XLEN-1:0]    rs_data;
    logic [XLEN-1:0]    rt_data;
    ctrl_t              ctrl;
    id_ex_t             id_ex_q;
    id_ex_t             id_ex_d;

    assign opcode = if_id_instr[OPC_LSB +: OPC_W];
    assign rs     = if_id_instr[RS_LSB +: REG_AW];
    assign rt     = if_id_instr[RT_LSB +: REG_AW];
    assign shamt  = if_id_instr[SHAMT_LSB +: REG_AW];
    assign funct  = if_id_instr[FUNCT_LSB +: FUNCT_W];
    assign imm16  = if_id_instr[IMM_LSB +: IMM_W];

    // Writeback is suppressed while reset is held so no value survives the clear.
    reg_file u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_we && !rst),
        .wa    (wb_addr),
        .wd    (wb_data),
        .ra0   (rs),
        .ra1   (rt),
        .rd0_c (rs_data),
        .rd1_c (rt_data)
    );

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = funct_to_alu(funct);
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    // Load-use hazard against the load sitting in ID/EX; a flush cancels it.
    assign id_stall = !rst && !flush && id_ex_q.valid && id_ex_q.ctrl.mem_read
                      && (id_ex_q.rt_addr != '0)
                      && ((id_ex_q.rt_addr == rs) || (id_ex_q.rt_addr == rt));

    always_comb begin
        id_ex_d = '0;
        if (!flush && !id_stall) begin
            id_ex_d.valid   = 1'b1;
            id_ex_d.npc     = if_id_NPC;
            id_ex_d.rs_data = rs_data;
            id_ex_d.rt_data = rt_data;
            id_ex_d.imm     = {{(XLEN-IMM_W){imm16[IMM_W-1]}}, imm16};
            id_ex_d.rs_addr = rs;
            id_ex_d.rt_addr = rt;
            id_ex_d.shamt   = shamt;
            id_ex_d.ctrl    = ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign id_ex_valid      = id_ex_q.valid;
    assign id_ex_NPC        = id_ex_q.npc;
    assign id_ex_rs_data    = id_ex_q.rs_data;
    assign id_ex_rt_data    = id_ex_q.rt_data;
    assign id_ex_imm        = id_ex_q.imm;
    assign id_ex_rs_addr    = id_ex_q.rs_addr;
    assign id_ex_rt_addr    = id_ex_q.rt_addr;
    assign id_ex_shamt      = id_ex_q.shamt;
    assign id_ex_alu_op     = id_ex_q.ctrl.alu_op;
    assign id_ex_alu_src    = id_ex_q.ctrl.alu_src;
    assign id_ex_reg_write  = id_ex_q.ctrl.reg_write;
    assign id_ex_mem_read   = id_ex_q.ctrl.mem_read;
    assign id_ex_mem_write  = id_ex_q.ctrl.mem_write;
    assign id_ex_mem_to_reg = id_ex_q.ctrl.mem_to_reg;
    assign id_ex_branch     = id_ex_q.ctrl.branch;

endmodule

// File: tb/tb_inst_decode.sv
// Directed bench for inst_decode: decode, bypass, load-use stall, flush, r0 and async reset.
module tb_inst_decode;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_id_instr;
    logic [9:0]  if_id_NPC;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_stall;
    logic        id_ex_valid;
    logic [9:0]  id_ex_NPC;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
    logic [4:0]  id_ex_rs_addr, id_ex_rt_addr, id_ex_shamt;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src, id_ex_reg_write, id_ex_mem_read;
    logic        id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch;

    int n_cmp = 0;
    int n_err = 0;

    inst_decode dut (
        .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_NPC(if_id_NPC),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_stall(id_stall), .id_ex_valid(id_ex_valid), .id_ex_NPC(id_ex_NPC),
        .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
        .id_ex_rs_addr(id_ex_rs_addr), .id_ex_rt_addr(id_ex_rt_addr), .id_ex_shamt(id_ex_shamt),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_branch(id_ex_branch)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Control bits packed as {alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}
    function automatic logic [5:0] ctl();
        return {id_ex_alu_src, id_ex_reg_write, id_ex_mem_read,
                id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (id_ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", id_ex_valid); end
        n_cmp++; if (ctl() !== 6'b0 || id_ex_alu_op !== 4'd0) begin n_err++; $display("FAIL reset_ctrl got %b/%h want 0", ctl(), id_ex_alu_op); end
        n_cmp++; if ({id_ex_imm, id_ex_rs_data, id_ex_rt_data, id_ex_NPC} !== '0) begin n_err++; $display("FAIL reset_data got nonzero want 0"); end
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", id_stall); end
        @(negedge clk); rst = 1'b0;
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL post_reset_stall got %b want 0", id_stall); end
    endtask

    task automatic test_addi();
        @(negedge clk);
        if_id_instr = enc_i(6'h08, 5'd0, 5'd1, 16'h8000);
        if_id_NPC   = 10'h011;
        @(posedge clk); #1;
        n_cmp++; if (id_ex_imm !== 32'hFFFF8000) begin n_err++; $display("FAIL addi_imm got %h want ffff8000", id_ex_imm); end
        n_cmp++; if (ctl() !== 6'b110000) begin n_err++; $display("FAIL addi_ctrl got %b want 110000", ctl()); end
        n_cmp++; if (id_ex_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b want 1", id_ex_valid); end
        n_cmp++; if (id_ex_alu_op !== 4'(ALU_ADD)) begin n_err++; $display("FAIL addi_aluop got %h want %h", id_ex_alu_op, 4'(ALU_ADD)); end
        n_cmp++; if (id_ex_NPC !== 10'h011 || id_ex_rt_addr !== 5'd1) begin n_err++; $display("FAIL addi_fields got npc=%h rt=%0d want 011/1", id_ex_NPC, id_ex_rt_addr); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        if_id_instr = enc_r(5'd5, 5'd0, 5'd6, 5'd0, FN_ADD);
        @(posedge clk); #1;
        n_cmp++; if (id_ex_rs_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_rs got %h want deadbeef", id_ex_rs_data); end
        n_cmp++; if (id_ex_rt_data !== 32'h0) begin n_err++; $display("FAIL bypass_rt0 got %h want 0", id_ex_rt_data); end
        n_cmp++; if (ctl() !== 6'b010000 || id_ex_alu_op !== 4'(ALU_ADD)) begin n_err++; $display("FAIL rtype_ctrl got %b/%h want 010000/%h", ctl(), id_ex_alu_op, 4'(ALU_ADD)); end
        @(negedge clk);
        wb_we = 1'b0;
        if_id_instr = enc_r(5'd2, 5'd5, 5'd7, 5'd3, FN_SUB);
        @(posedge clk); #1;
        n_cmp++; if (id_ex_rt_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_r5 got %h want deadbeef", id_ex_rt_data); end
        n_cmp++; if (id_ex_alu_op !== 4'(ALU_SUB) || id_ex_shamt !== 5'd3 || id_ex_rs_addr !== 5'd2) begin n_err++; $display("FAIL sub_fields got op=%h sh=%0d rs=%0d want %h/3/2", id_ex_alu_op, id_ex_shamt, id_ex_rs_addr, 4'(ALU_SUB)); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        if_id_instr = enc_i(6'h23, 5'd2, 5'd3, 16'h0004);
        @(posedge clk); #1;
        n_cmp++; if (ctl() !== 6'b111010 || id_ex_imm !== 32'h4) begin n_err++; $display("FAIL lw_ctrl got %b imm=%h want 111010/4", ctl(), id_ex_imm); end
        if_id_instr = enc_r(5'd3, 5'd2, 5'd4, 5'd0, FN_ADD);
        #1;
        n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b want 1", id_stall); end
        @(posedge clk); #1;
        n_cmp++; if (id_ex_valid !== 1'b0 || ctl() !== 6'b0) begin n_err++; $display("FAIL lu_bubble got v=%b c=%b want 0/0", id_ex_valid, ctl()); end
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_clear got %b want 0", id_stall); end
        @(posedge clk); #1;
        n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_rs_addr !== 5'd3 || ctl() !== 6'b010000) begin n_err++; $display("FAIL lu_issue got v=%b rs=%0d c=%b want 1/3/010000", id_ex_valid, id_ex_rs_addr, ctl()); end
    endtask

    task automatic test_flush_stall();
        @(negedge clk);
        if_id_instr = enc_i(6'h23, 5'd2, 5'd3, 16'h0008);
        @(posedge clk); #1;
        if_id_instr = enc_r(5'd2, 5'd3, 5'd4, 5'd0, FN_ADD);
        #1;
        n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL fl_pre_stall got %b want 1", id_stall); end
        flush = 1'b1;
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL fl_stall_forced got %b want 0", id_stall); end
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (id_ex_valid !== 1'b0 || ctl() !== 6'b0) begin n_err++; $display("FAIL fl_bubble got v=%b c=%b want 0/0", id_ex_valid, ctl()); end
        @(posedge clk); #1;
        n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_rt_addr !== 5'd3) begin n_err++; $display("FAIL fl_resume got v=%b rt=%0d want 1/3", id_ex_valid, id_ex_rt_addr); end
    endtask

    task automatic test_r0_and_nop();
        @(negedge clk);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        if_id_instr = enc_r(5'd0, 5'd0, 5'd8, 5'd0, FN_OR);
        @(posedge clk); #1;
        n_cmp++; if (id_ex_rs_data !== 32'h0) begin n_err++; $display("FAIL r0_bypass got %h want 0", id_ex_rs_data); end
        n_cmp++; if (id_ex_alu_op !== 4'(ALU_OR)) begin n_err++; $display("FAIL or_aluop got %h want %h", id_ex_alu_op, 4'(ALU_OR)); end
        @(negedge clk);
        wb_we = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (id_ex_rs_data !== 32'h0 || id_ex_rt_data !== 32'h0) begin n_err++; $display("FAIL r0_read got %h/%h want 0/0", id_ex_rs_data, id_ex_rt_data); end
        @(negedge clk);
        if_id_instr = 32'hFFFFFFFF;
        @(posedge clk); #1;
        n_cmp++; if (ctl() !== 6'b0 || id_ex_alu_op !== 4'd0) begin n_err++; $display("FAIL nop_ctrl got %b/%h want 0/0", ctl(), id_ex_alu_op); end
        n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL nop_valid got v=%b imm=%h want 1/ffffffff", id_ex_valid, id_ex_imm); end
    endtask

    task automatic test_beq_sw();
        @(negedge clk);
        if_id_instr = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE);
        @(posedge clk); #1;
        n_cmp++; if (ctl() !== 6'b000001 || id_ex_alu_op !== 4'(ALU_SUB) || id_ex_imm !== 32'hFFFFFFFE) begin n_err++; $display("FAIL beq got c=%b op=%h imm=%h want 000001/%h/fffffffe", ctl(), id_ex_alu_op, id_ex_imm, 4'(ALU_SUB)); end
        @(negedge clk);
        if_id_instr = enc_i(6'h2B, 5'd1, 5'd2, 16'h7FF0);
        @(posedge clk); #1;
        n_cmp++; if (ctl() !== 6'b100100 || id_ex_imm !== 32'h00007FF0) begin n_err++; $display("FAIL sw got c=%b imm=%h want 100100/00007ff0", ctl(), id_ex_imm); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        if_id_instr = enc_r(5'd0, 5'd0, 5'd9, 5'd0, FN_ADD);
        @(posedge clk); #1;
        wb_we = 1'b0;
        if_id_instr = enc_i(6'h23, 5'd7, 5'd3, 16'h0010);
        @(posedge clk); #1;
        n_cmp++; if (id_ex_rs_data !== 32'h77) begin n_err++; $display("FAIL r7_written got %h want 77", id_ex_rs_data); end
        if_id_instr = enc_r(5'd3, 5'd2, 5'd4, 5'd0, FN_ADD);
        #1;
        n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL ar_pre_stall got %b want 1", id_stall); end
        #1;
        rst = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        #1;
        n_cmp++; if (id_ex_valid !== 1'b0 || ctl() !== 6'b0 || id_ex_imm !== 32'h0 || id_ex_rs_data !== 32'h0 || id_ex_rt_addr !== 5'd0) begin n_err++; $display("FAIL ar_clear got v=%b c=%b imm=%h rs=%h", id_ex_valid, ctl(), id_ex_imm, id_ex_rs_data); end
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL ar_stall got %b want 0", id_stall); end
        @(negedge clk);
        rst = 1'b0; wb_we = 1'b0;
        if_id_instr = enc_r(5'd7, 5'd0, 5'd9, 5'd0, FN_ADD);
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL ar_post_stall got %b want 0", id_stall); end
        @(posedge clk); #1;
        n_cmp++; if (id_ex_rs_data !== 32'h0 || id_ex_valid !== 1'b1) begin n_err++; $display("FAIL ar_r7 got %h v=%b want 0/1", id_ex_rs_data, id_ex_valid); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        if_id_instr = '0; if_id_NPC = '0;
        #2;
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_flush_stall();
        test_r0_and_nop();
        test_beq_sw();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_decode.md
INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 SHALL have ports as follows (clock and reset first); one clock; reset is asynchronous and active-high:
clk  in  1  sole clock, posedge
rst  in  1  asynchronous active-high reset
if_id_instr  in  32  instruction from IF/ID register
if_id_NPC  in  10  PC+1 from IF/ID register
flush  in  1  taken branch/jump resolved in EX (same signal that drives PCSrc)
wb_we  in  1  writeback enable
wb_addr  in  5  writeback register index
wb_data  in  32  writeback value
id_stall  out  1  load-use stall request to IF (hold PC and IF/ID)
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_NPC  out  10  registered if_id_NPC
id_ex_rs_data, id_ex_rt_data  out  32 each  registered operands
id_ex_imm  out  32  registered sign-extended imm16
id_ex_rs_addr, id_ex_rt_addr  out  5 each  registered source indices
id_ex_shamt  out  5  registered shamt
id_ex_alu_op  out  4  ALU operation code
id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch  out  1 each  control bits

Function
REQ-002 SHALL split the instruction as opcode[31:26], rs[25:21], rt[20:16], imm16[15:0], shamt[10:6], funct[5:0].
REQ-003 SHALL decode opcodes: 0x00 R-type (alu_op from funct, reg_write=1); 0x08 ADDI (alu_src=1, reg_write=1, alu_op=ADD); 0x23 LW (alu_src, mem_read, mem_to_reg, reg_write); 0x2B SW (alu_src, mem_write); 0x04 BEQ (branch=1, alu_op=SUB); any other opcode SHALL decode as NOP (all control bits 0).
REQ-004 SHALL sign-extend imm16 to 32 bits (bit 15 replicated).
REQ-005 SHALL contain a 32x32 register file; register 0 SHALL read 0 and ignore writes.
REQ-006 SHALL write wb_data to wb_addr on posedge clk when wb_we=1 and wb_addr!=0.
REQ-007 SHALL bypass a same-cycle write: a read of index wb_addr (nonzero) while wb_we=1 returns wb_data.
REQ-008 SHALL register all id_ex_* outputs on posedge clk; decode-to-ID/EX latency is exactly one cycle.
REQ-009 SHALL assert id_stall combinationally when id_ex_valid=1, id_ex_mem_read=1, id_ex_rt_addr!=0, and id_ex_rt_addr equals current rs or rt.
REQ-010 SHALL, on a stall cycle, load a bubble into ID/EX (id_ex_valid=0, all control bits 0; data fields don't-care).
REQ-011 SHALL, when flush=1, load a bubble into ID/EX at the next edge and SHALL force id_stall=0.
REQ-012 SHALL apply priority reset > flush > stall > normal load.
REQ-013 SHALL drive id_ex_valid=1 on normal load of any opcode, including NOP-decoded ones.

Reset
REQ-014 SHALL, while rst=1, clear all 32 registers and all id_ex_* outputs to 0 asynchronously.
REQ-015 SHALL output id_stall=0 during reset and in the first cycle after release.
REQ-016 SHALL ignore wb_we while rst=1; a reset asserted mid-stall SHALL leave a bubble and no pending stall.

Structure
REQ-017 SHALL take opcode values, alu_op encodings, and field bit positions from shared package isa_pkg, which the EX stage also uses.
REQ-018 SHALL implement the register file as sub-module reg_file (2 async read ports, 1 sync write port, internal bypass); decode, hazard, and ID/EX logic stay in inst_decode.

Verification
REQ-019 Reset, then ADDI r1,r0,0x8000 -> next cycle id_ex_imm=0xFFFF8000, alu_src=1, reg_write=1, id_ex_valid=1.
REQ-020 wb_we=1, wb_addr=5, wb_data=0xDEADBEEF in the same cycle as an R-type with rs=5 -> id_ex_rs_data=0xDEADBEEF next cycle.
REQ-021 LW r3 followed by ADD r4,r3,r2 -> id_stall=1 for one cycle, ID/EX bubble, then ADD issues with id_ex_valid=1.
REQ-022 flush=1 during a load-use stall -> id_stall=0, ID/EX bubble at next edge.
REQ-023 Write 0x1234 to r0, then read r0 -> 0; opcode 0x3F -> all controls 0, id_ex_valid=1.
REQ-024 Assert rst asynchronously mid-cycle with nonzero ID/EX state -> all id_ex_* =0 before the next edge; previously written r7 reads 0.
